// File: rtl/lpif_txrx_asym_gearbox_if.sv
// ---------------------------------------------------------------------------
// lpif_txrx_asym_gearbox_if
//
// Bundles the beat-side (LPIF adapter) and word-side (logic-link FIFO)
// signals of the asymmetric gearbox.
//
// Parameters: RATIO (beats per word), STATE_W, PROTID_W, DATA_W, CRC_W.
//
// Signal groups:
//   ustrm_*   upstream beat into the gearbox (ustrm_ready comes back)
//   txfifo_*  packed word toward the TX FIFO (txfifo_ready comes back)
//   rxfifo_*  packed word from the RX FIFO (rxfifo_pop goes back)
//   dstrm_*   unpacked beat out of the gearbox
//
// Modports:
//   slave   the gearbox itself
//   master  the surroundings (adapter + FIFOs), e.g. a testbench
// ---------------------------------------------------------------------------
interface lpif_txrx_asym_gearbox_if #(
   parameter int RATIO    = 2,
   parameter int STATE_W  = 4,
   parameter int PROTID_W = 2,
   parameter int DATA_W   = 256,
   parameter int CRC_W    = 16
);
   localparam int BEAT_W = STATE_W + PROTID_W + DATA_W + CRC_W + 3;
   localparam int LL_W   = RATIO * BEAT_W;

   // upstream beat
   logic                ustrm_beat;
   logic                ustrm_ready;
   logic [STATE_W-1:0]  ustrm_state;
   logic [PROTID_W-1:0] ustrm_protid;
   logic [DATA_W-1:0]   ustrm_data;
   logic [CRC_W-1:0]    ustrm_crc;
   logic                ustrm_dvalid;
   logic                ustrm_crc_valid;
   logic                ustrm_valid;

   // TX FIFO side
   logic [LL_W-1:0]     txfifo_upstream_data;
   logic                txfifo_push;
   logic                txfifo_ready;

   // RX FIFO side
   logic [LL_W-1:0]     rxfifo_downstream_data;
   logic                rxfifo_valid;
   logic                rxfifo_pop;

   // downstream beat
   logic                dstrm_beat;
   logic [STATE_W-1:0]  dstrm_state;
   logic [PROTID_W-1:0] dstrm_protid;
   logic [DATA_W-1:0]   dstrm_data;
   logic [CRC_W-1:0]    dstrm_crc;
   logic                dstrm_dvalid;
   logic                dstrm_crc_valid;
   logic                dstrm_valid;

   modport slave (
      input  ustrm_beat, ustrm_state, ustrm_protid, ustrm_data, ustrm_crc,
             ustrm_dvalid, ustrm_crc_valid, ustrm_valid,
      output ustrm_ready,
      output txfifo_upstream_data, txfifo_push,
      input  txfifo_ready,
      input  rxfifo_downstream_data, rxfifo_valid,
      output rxfifo_pop,
      output dstrm_beat, dstrm_state, dstrm_protid, dstrm_data, dstrm_crc,
             dstrm_dvalid, dstrm_crc_valid, dstrm_valid
   );

   modport master (
      output ustrm_beat, ustrm_state, ustrm_protid, ustrm_data, ustrm_crc,
             ustrm_dvalid, ustrm_crc_valid, ustrm_valid,
      input  ustrm_ready,
      input  txfifo_upstream_data, txfifo_push,
      output txfifo_ready,
      output rxfifo_downstream_data, rxfifo_valid,
      input  rxfifo_pop,
      input  dstrm_beat, dstrm_state, dstrm_protid, dstrm_data, dstrm_crc,
             dstrm_dvalid, dstrm_crc_valid, dstrm_valid
   );
endinterface

// File: rtl/lpif_txrx_asym_gearbox.sv
// ---------------------------------------------------------------------------
// lpif_txrx_asym_gearbox
//
// Ratio-generic gearbox between a single-beat LPIF adapter and the wide
// logic-link FIFOs of an asymmetric AIB channel.
//   TX: packs RATIO accepted upstream beats into one word, slot k at
//       word bits [k*BEAT_W +: BEAT_W].
//   RX: unpacks one popped word into RATIO consecutive downstream beats.
//
// Slot layout, LSB first: state, protid, data, dvalid, crc, crc_valid, valid.
//
// Handshakes:
//   upstream : a beat transfers on a cycle with ustrm_beat && ustrm_ready.
//              A beat strobed without ustrm_ready is dropped and sets tx_ovf.
//   TX FIFO  : txfifo_push holds a stable word until a cycle with
//              txfifo_ready=1; that cycle is the transfer.
//   RX FIFO  : the word on rxfifo_downstream_data transfers on a cycle with
//              rxfifo_valid && rxfifo_pop.
//   downstream: dstrm_beat qualifies dstrm_* each cycle (no back-pressure).
//
// Ports:
//   lclk, rst       clock, synchronous active-high reset
//   align           one-cycle pulse: restart both phase counters at slot 0
//   bus             gearbox side (slave) of lpif_txrx_asym_gearbox_if
//   tx_phase        slot the next upstream beat will fill
//   rx_phase        slot currently presented on dstrm_*
//   tx_ovf          sticky: a beat was strobed while ustrm_ready=0
// ---------------------------------------------------------------------------
module lpif_txrx_asym_gearbox #(
   parameter int RATIO    = 2,
   parameter int STATE_W  = 4,
   parameter int PROTID_W = 2,
   parameter int DATA_W   = 256,
   parameter int CRC_W    = 16
) (
   input  logic                        lclk,
   input  logic                        rst,
   input  logic                        align,
   lpif_txrx_asym_gearbox_if.slave     bus,
   output logic [1:0]                  tx_phase,
   output logic [1:0]                  rx_phase,
   output logic                        tx_ovf
);
   localparam int BEAT_W = STATE_W + PROTID_W + DATA_W + CRC_W + 3;
   localparam int LL_W   = RATIO * BEAT_W;
   localparam logic [1:0] LAST = 2'(RATIO - 1);

   // field offsets inside one slot
   localparam int OFF_P  = STATE_W;
   localparam int OFF_D  = OFF_P + PROTID_W;
   localparam int OFF_DV = OFF_D + DATA_W;
   localparam int OFF_C  = OFF_DV + 1;
   localparam int OFF_CV = OFF_C + CRC_W;
   localparam int OFF_V  = OFF_CV + 1;

   // ------------------------------------------------------------------
   // TX pack
   // ------------------------------------------------------------------
   logic [BEAT_W-1:0] in_beat;
   logic [LL_W-1:0]   tx_asm;
   logic [LL_W-1:0]   tx_asm_next;
   logic [LL_W-1:0]   tx_word;
   logic              tx_push;
   logic              tx_last;
   logic              tx_ready;
   logic              tx_accept;

   assign in_beat = {bus.ustrm_valid, bus.ustrm_crc_valid, bus.ustrm_crc,
                     bus.ustrm_dvalid, bus.ustrm_data, bus.ustrm_protid,
                     bus.ustrm_state};

   assign tx_last   = (tx_phase == LAST);
   // Only the completing beat can collide with a pending output word;
   // earlier slots land in the assembly register and are always taken.
   assign tx_ready  = !tx_push || bus.txfifo_ready || !tx_last;
   assign tx_accept = bus.ustrm_beat && tx_ready && !align;

   // New beats enter at the top slot and shift down, so after RATIO
   // accepts the first beat sits in slot 0 and the last in slot RATIO-1.
   assign tx_asm_next = (tx_asm >> BEAT_W) | (LL_W'(in_beat) << (LL_W - BEAT_W));

   always_ff @(posedge lclk) begin
      if (rst) begin
         tx_asm   <= '0;
         tx_word  <= '0;
         tx_push  <= 1'b0;
         tx_phase <= 2'd0;
         tx_ovf   <= 1'b0;
      end else begin
         if (bus.ustrm_beat && !tx_ready && !align)
            tx_ovf <= 1'b1;

         if (align) begin
            tx_asm   <= '0;
            tx_phase <= 2'd0;
         end else if (tx_accept) begin
            tx_asm   <= tx_last ? '0 : tx_asm_next;
            tx_phase <= tx_last ? 2'd0 : tx_phase + 2'd1;
         end

         // A completing beat is only accepted when the output slot is free
         // or being drained this cycle, so it never overwrites a live word.
         if (tx_accept && tx_last) begin
            tx_word <= tx_asm_next;
            tx_push <= 1'b1;
         end else if (bus.txfifo_ready) begin
            tx_push <= 1'b0;
         end
      end
   end

   assign bus.ustrm_ready          = tx_ready;
   assign bus.txfifo_upstream_data = tx_word;
   assign bus.txfifo_push          = tx_push;

   // ------------------------------------------------------------------
   // RX unpack
   // ------------------------------------------------------------------
   logic [LL_W-1:0] rx_buf;
   logic            rx_full;
   logic            rx_last;
   logic            rx_pop;

   assign rx_last = (rx_phase == LAST);
   // Popping is held off during rst/align so a FIFO word is never consumed
   // in a cycle that would immediately discard it.
   assign rx_pop  = bus.rxfifo_valid && !rst && !align && (!rx_full || rx_last);

   // The presented slot is always the low slot of rx_buf; the buffer shifts
   // down one slot per emitted beat.
   always_ff @(posedge lclk) begin
      if (rst || align) begin
         rx_buf   <= '0;
         rx_full  <= 1'b0;
         rx_phase <= 2'd0;
      end else if (rx_pop) begin
         rx_buf   <= bus.rxfifo_downstream_data;
         rx_full  <= 1'b1;
         rx_phase <= 2'd0;
      end else if (rx_full) begin
         if (rx_last) begin
            rx_full  <= 1'b0;
            rx_phase <= 2'd0;
         end else begin
            rx_buf   <= rx_buf >> BEAT_W;
            rx_phase <= rx_phase + 2'd1;
         end
      end
   end

   assign bus.rxfifo_pop      = rx_pop;
   assign bus.dstrm_beat      = rx_full;
   assign bus.dstrm_state     = rx_buf[0 +: STATE_W];
   assign bus.dstrm_protid    = rx_buf[OFF_P +: PROTID_W];
   assign bus.dstrm_data      = rx_buf[OFF_D +: DATA_W];
   assign bus.dstrm_dvalid    = rx_buf[OFF_DV];
   assign bus.dstrm_crc       = rx_buf[OFF_C +: CRC_W];
   assign bus.dstrm_crc_valid = rx_buf[OFF_CV];
   assign bus.dstrm_valid     = rx_buf[OFF_V];

endmodule

// File: tb/tb_lpif_txrx_asym_gearbox.sv
// ---------------------------------------------------------------------------
// tb_lpif_txrx_asym_gearbox
//
// Drives three gearboxes (RATIO 1, 2, 4) from one shared stimulus stream
// and compares every cycle against a beat-list reference model: TX keeps
// the list of accepted beats of the current word, RX keeps the list of
// beats of the current word still to be emitted.
// ---------------------------------------------------------------------------
module tb_lpif_txrx_asym_gearbox;
   localparam int STATE_W  = 4;
   localparam int PROTID_W = 2;
   localparam int DATA_W   = 256;
   localparam int CRC_W    = 16;
   localparam int BEAT_W   = STATE_W + PROTID_W + DATA_W + CRC_W + 3;
   localparam int MAXW     = 4 * BEAT_W;
   localparam int NI       = 3;

   // ---------------- clock / reset ----------------
   logic lclk = 1'b0;
   always #5 lclk = ~lclk;

   logic rst, align, ustrm_beat, txfifo_ready, rxfifo_valid;
   logic [STATE_W-1:0]  u_state;
   logic [PROTID_W-1:0] u_protid;
   logic [DATA_W-1:0]   u_data;
   logic [CRC_W-1:0]    u_crc;
   logic                u_dvalid, u_crcv, u_valid;
   logic [MAXW-1:0]     rx_word;

   // per-instance observed outputs
   logic              o_ready [NI];
   logic              o_push  [NI];
   logic              o_pop   [NI];
   logic              o_dbeat [NI];
   logic              o_ovf   [NI];
   logic [1:0]        o_txph  [NI];
   logic [1:0]        o_rxph  [NI];
   logic [MAXW-1:0]   o_word  [NI];
   logic [BEAT_W-1:0] o_dslot [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int R = (g == 0) ? 1 : (g == 1) ? 2 : 4;
      logic [1:0] tx_phase, rx_phase;
      logic       tx_ovf;

      lpif_txrx_asym_gearbox_if #(.RATIO(R), .STATE_W(STATE_W), .PROTID_W(PROTID_W),
                                  .DATA_W(DATA_W), .CRC_W(CRC_W)) bus ();

      assign bus.ustrm_beat             = ustrm_beat;
      assign bus.ustrm_state            = u_state;
      assign bus.ustrm_protid           = u_protid;
      assign bus.ustrm_data             = u_data;
      assign bus.ustrm_crc              = u_crc;
      assign bus.ustrm_dvalid           = u_dvalid;
      assign bus.ustrm_crc_valid        = u_crcv;
      assign bus.ustrm_valid            = u_valid;
      assign bus.txfifo_ready           = txfifo_ready;
      assign bus.rxfifo_valid           = rxfifo_valid;
      assign bus.rxfifo_downstream_data = rx_word[R*BEAT_W-1:0];

      lpif_txrx_asym_gearbox #(.RATIO(R), .STATE_W(STATE_W), .PROTID_W(PROTID_W),
                               .DATA_W(DATA_W), .CRC_W(CRC_W)) u_dut (
         .lclk     (lclk),
         .rst      (rst),
         .align    (align),
         .bus      (bus),
         .tx_phase (tx_phase),
         .rx_phase (rx_phase),
         .tx_ovf   (tx_ovf)
      );

      assign o_ready[g] = bus.ustrm_ready;
      assign o_push[g]  = bus.txfifo_push;
      assign o_pop[g]   = bus.rxfifo_pop;
      assign o_dbeat[g] = bus.dstrm_beat;
      assign o_ovf[g]   = tx_ovf;
      assign o_txph[g]  = tx_phase;
      assign o_rxph[g]  = rx_phase;
      assign o_word[g]  = MAXW'(bus.txfifo_upstream_data);
      assign o_dslot[g] = {bus.dstrm_valid, bus.dstrm_crc_valid, bus.dstrm_crc,
                           bus.dstrm_dvalid, bus.dstrm_data, bus.dstrm_protid,
                           bus.dstrm_state};
   end

   // ---------------- reference model state ----------------
   logic [BEAT_W-1:0] m_part [NI][4];   // accepted beats of the word being built
   int                m_part_n [NI];
   logic [MAXW-1:0]   m_word [NI];      // word offered to the TX FIFO
   logic              m_push [NI];
   logic              m_ovf  [NI];
   logic [BEAT_W-1:0] m_rem [NI][4];    // beats still to emit, [0] = on dstrm now
   int                m_rem_n [NI];

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [BEAT_W-1:0] got,
                        input logic [BEAT_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int ratio_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 2 : 4;
   endfunction

   // beat layout, LSB first: state, protid, data, dvalid, crc, crc_valid, valid
   function automatic logic [BEAT_W-1:0] cur_beat();
      return {u_valid, u_crcv, u_crc, u_dvalid, u_data, u_protid, u_state};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic rand_fields();
      u_state  = STATE_W'($urandom);
      u_protid = PROTID_W'($urandom);
      for (int j = 0; j < DATA_W / 32; j++) u_data[j*32 +: 32] = $urandom;
      u_crc    = CRC_W'($urandom);
      u_dvalid = 1'($urandom);
      u_crcv   = 1'($urandom);
      u_valid  = 1'($urandom);
   endtask

   task automatic rand_rx_word();
      logic [1151:0] t;
      for (int j = 0; j < 36; j++) t[j*32 +: 32] = $urandom;
      rx_word = t[MAXW-1:0];
   endtask

   task automatic check_regs();
      int r;
      for (int i = 0; i < NI; i++) begin
         r = ratio_of(i);
         check($sformatf("r%0d tx_phase", r), BEAT_W'(o_txph[i]), BEAT_W'(m_part_n[i]));
         check($sformatf("r%0d txfifo_push", r), BEAT_W'(o_push[i]), BEAT_W'(m_push[i]));
         check($sformatf("r%0d tx_ovf", r), BEAT_W'(o_ovf[i]), BEAT_W'(m_ovf[i]));
         if (m_push[i])
            for (int k = 0; k < r; k++)
               check($sformatf("r%0d word slot%0d", r, k), o_word[i][k*BEAT_W +: BEAT_W],
                     m_word[i][k*BEAT_W +: BEAT_W]);
         check($sformatf("r%0d dstrm_beat", r), BEAT_W'(o_dbeat[i]), BEAT_W'(m_rem_n[i] > 0));
         check($sformatf("r%0d rx_phase", r), BEAT_W'(o_rxph[i]),
               BEAT_W'((m_rem_n[i] > 0) ? r - m_rem_n[i] : 0));
         if (m_rem_n[i] > 0)
            check($sformatf("r%0d dstrm slot", r), o_dslot[i], m_rem[i][0]);
      end
   endtask

   // One clock cycle: inputs are already set by the caller.
   task automatic step();
      logic exp_ready, exp_pop, acc;
      logic [MAXW-1:0] w;
      int r;
      #1;
      for (int i = 0; i < NI; i++) begin
         r = ratio_of(i);
         exp_ready = !(m_push[i] && !txfifo_ready && m_part_n[i] == r - 1);
         exp_pop   = rxfifo_valid && !align && m_rem_n[i] <= 1;
         check($sformatf("r%0d ustrm_ready", r), BEAT_W'(o_ready[i]), BEAT_W'(exp_ready));
         check($sformatf("r%0d rxfifo_pop", r), BEAT_W'(o_pop[i]), BEAT_W'(exp_pop));

         acc = ustrm_beat && exp_ready && !align;
         if (align) m_part_n[i] = 0;
         else if (ustrm_beat && !exp_ready) m_ovf[i] = 1'b1;
         if (acc) begin
            m_part[i][m_part_n[i]] = cur_beat();
            m_part_n[i]++;
         end
         if (acc && m_part_n[i] == r) begin
            w = '0;
            for (int k = 0; k < r; k++) w[k*BEAT_W +: BEAT_W] = m_part[i][k];
            m_word[i]   = w;
            m_push[i]   = 1'b1;
            m_part_n[i] = 0;
         end else if (txfifo_ready) begin
            m_push[i] = 1'b0;
         end

         if (align) begin
            m_rem_n[i] = 0;
         end else begin
            if (m_rem_n[i] > 0) begin
               for (int k = 0; k < 3; k++) m_rem[i][k] = m_rem[i][k+1];
               m_rem_n[i]--;
            end
            if (exp_pop) begin
               for (int k = 0; k < r; k++) m_rem[i][k] = rx_word[k*BEAT_W +: BEAT_W];
               m_rem_n[i] = r;
            end
         end
      end
      @(posedge lclk);
      #1;
      check_regs();
      @(negedge lclk);
   endtask

   task automatic do_reset();
      int r;
      rst = 1'b1; align = 1'b0; ustrm_beat = 1'b0;
      txfifo_ready = 1'b0; rxfifo_valid = 1'b0;
      repeat (3) @(negedge lclk);
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
         m_part_n[i] = 0; m_push[i] = 1'b0; m_ovf[i] = 1'b0;
         m_rem_n[i] = 0; m_word[i] = '0;
      end
      #1;
      for (int i = 0; i < NI; i++) begin
         r = ratio_of(i);
         check($sformatf("r%0d rst ustrm_ready", r), BEAT_W'(o_ready[i]), BEAT_W'(1));
         check($sformatf("r%0d rst push", r), BEAT_W'(o_push[i]), '0);
         check($sformatf("r%0d rst pop", r), BEAT_W'(o_pop[i]), '0);
         check($sformatf("r%0d rst tx_phase", r), BEAT_W'(o_txph[i]), '0);
         check($sformatf("r%0d rst rx_phase", r), BEAT_W'(o_rxph[i]), '0);
         check($sformatf("r%0d rst tx_ovf", r), BEAT_W'(o_ovf[i]), '0);
         check($sformatf("r%0d rst dstrm_beat", r), BEAT_W'(o_dbeat[i]), '0);
         check($sformatf("r%0d rst dstrm fields", r), o_dslot[i], '0);
         for (int k = 0; k < r; k++)
            check($sformatf("r%0d rst word slot%0d", r, k), o_word[i][k*BEAT_W +: BEAT_W], '0);
      end
   endtask

   // ---------------- test sequence ----------------
   logic [DATA_W-1:0] data_a, data_b, data_c;
   int beats_r4, pops_r4;

   initial begin
      rx_word = '0;
      rand_fields();
      do_reset();

      // idle after reset
      txfifo_ready = 1'b1;
      repeat (10) step();

      // TX pack: A then B
      rand_fields(); data_a = u_data; ustrm_beat = 1'b1; step();
      rand_fields(); data_b = u_data; step();
      check("r2 word data A at bit 6", BEAT_W'(o_word[1][6 +: 256]), BEAT_W'(data_a));
      check("r2 word data B at bit 287", BEAT_W'(o_word[1][287 +: 256]), BEAT_W'(data_b));
      ustrm_beat = 1'b0; step();

      // TX backpressure: 4 beats then an empty cycle with txfifo_ready=0
      do_reset();
      txfifo_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         rand_fields(); ustrm_beat = 1'b1; step();
      end
      ustrm_beat = 1'b0; step();
      check("r2 tx_ovf after refused beat", BEAT_W'(o_ovf[1]), BEAT_W'(1));
      txfifo_ready = 1'b1; step(); step();

      // RX unpack: two words back-to-back into the RATIO=4 instance
      do_reset();
      txfifo_ready = 1'b1;
      beats_r4 = 0; pops_r4 = 0;
      for (int c = 0; c < 11; c++) begin
         rxfifo_valid = (c <= 4);
         rand_rx_word();
         #1;
         if (o_pop[2]) pops_r4++;
         step();
         if (o_dbeat[2]) beats_r4++;
      end
      check("r4 dstrm beats for two words", BEAT_W'(beats_r4), BEAT_W'(8));
      check("r4 pops for two words", BEAT_W'(pops_r4), BEAT_W'(2));

      // Align mid-word
      do_reset();
      txfifo_ready = 1'b1; rxfifo_valid = 1'b1; rand_rx_word();
      rand_fields(); ustrm_beat = 1'b1; step();
      rxfifo_valid = 1'b0;
      rand_fields(); align = 1'b1; step();
      align = 1'b0;
      check("r2 dstrm_beat after align", BEAT_W'(o_dbeat[1]), '0);
      check("r2 rx_phase after align", BEAT_W'(o_rxph[1]), '0);
      rand_fields(); data_c = u_data; step();
      rand_fields(); step();
      check("r2 post-align beat in slot0", BEAT_W'(o_word[1][6 +: 256]), BEAT_W'(data_c));
      ustrm_beat = 1'b0; step();

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         ustrm_beat   = ($urandom_range(0, 3) != 0);
         txfifo_ready = ($urandom_range(0, 3) != 0);
         rxfifo_valid = 1'($urandom_range(0, 1));
         align        = ($urandom_range(0, 49) == 0);
         rand_fields();
         rand_rx_word();
         step();
      end
      align = 1'b0; ustrm_beat = 1'b0; rxfifo_valid = 1'b0;
      repeat (5) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
